uart_bus_init: RTL

//  Bus initiator: the other end of the uart bus_* responder port (trans/addr/write/wdata -> ready/resp/rdata).

---
 rtl/uart_bus_init_if.sv | 44 ++++
 rtl/uart_bus_init.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/uart_bus_init_if.sv
// Signal bundle between uart_bus_init and its command source / bus responder.
// master: the initiator block itself; slave: command source plus bus responder.
interface uart_bus_init_if #(
    parameter int unsigned AddrW = 32,
    parameter int unsigned DataW = 32
);
    logic             cmd_valid_i;
    logic             cmd_ready_o;
    logic             cmd_write_i;
    logic [AddrW-1:0] cmd_addr_i;
    logic [DataW-1:0] cmd_wdata_i;

    logic             rsp_valid_o;
    logic             rsp_ready_i;
    logic [DataW-1:0] rsp_rdata_o;
    logic             rsp_err_o;
    logic             rsp_tout_o;

    logic [1:0]       bus_trans_o;
    logic [AddrW-1:0] bus_addr_o;
    logic             bus_write_o;
    logic [DataW-1:0] bus_wdata_o;
    logic             bus_ready_i;
    logic             bus_resp_i;
    logic [DataW-1:0] bus_rdata_i;

    modport master (
        input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i,
        input  rsp_ready_i,
        input  bus_ready_i, bus_resp_i, bus_rdata_i,
        output cmd_ready_o,
        output rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_tout_o,
        output bus_trans_o, bus_addr_o, bus_write_o, bus_wdata_o
    );

    modport slave (
        output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i,
        output rsp_ready_i,
        output bus_ready_i, bus_resp_i, bus_rdata_i,
        input  cmd_ready_o,
        input  rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_tout_o,
        input  bus_trans_o, bus_addr_o, bus_write_o, bus_wdata_o
    );
endinterface

// File: rtl/uart_bus_init.sv
// Single-transfer bus initiator: one command -> address + data phase -> one response.
// Optional data-phase timeout enabled by `define UART_BUS_INIT_TIMEOUT_EN.
module uart_bus_init #(
    parameter int unsigned AddrW      = 32,
    parameter int unsigned DataW      = 32,
    parameter int unsigned TimeoutCyc = 255
) (
    input  logic            main_clk_i,
    input  logic            main_rst_i,
    uart_bus_init_if.master bus
);
    localparam logic [1:0] TransIdle   = 2'd0;
    localparam logic [1:0] TransNonseq = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_RSP
    } state_t;

    state_t state, state_nxt;

    logic             cmd_take;
    logic             bus_done;
    logic             tout_hit;
    logic             cmd_ready;
    logic             rsp_valid;
    logic [1:0]       trans;

    logic             write_q;
    logic [AddrW-1:0] addr_q;
    logic [DataW-1:0] wdata_q;
    logic [DataW-1:0] rdata_q;
    logic             err_q;
    logic             tout_q;

    always_ff @(posedge main_clk_i) begin
        if (main_rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cmd_take  = 1'b0;
        bus_done  = 1'b0;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        trans     = TransIdle;
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (bus.cmd_valid_i) begin
                    cmd_take  = 1'b1;
                    state_nxt = S_ADDR;
                end
            end
            S_ADDR: begin
                trans     = TransNonseq;
                state_nxt = S_DATA;
            end
            S_DATA: begin
                if (bus.bus_ready_i) begin
                    bus_done  = 1'b1;
                    state_nxt = S_RSP;
                end else if (tout_hit) begin
                    state_nxt = S_RSP;
                end
            end
            S_RSP: begin
                rsp_valid = 1'b1;
                if (bus.rsp_ready_i) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

`ifdef UART_BUS_INIT_TIMEOUT_EN
    logic [15:0] tcnt_q;

    // Fires on the wait cycle that brings the count up to TimeoutCyc.
    assign tout_hit = (state == S_DATA) && !bus.bus_ready_i &&
                      (tcnt_q == 16'(TimeoutCyc - 1));

    always_ff @(posedge main_clk_i) begin
        if (main_rst_i) begin
            tcnt_q <= '0;
        end else if (cmd_take) begin
            tcnt_q <= '0;
        end else if ((state == S_DATA) && !bus.bus_ready_i) begin
            tcnt_q <= tcnt_q + 16'd1;
        end
    end
`else
    assign tout_hit = 1'b0;
`endif

    always_ff @(posedge main_clk_i) begin
        if (main_rst_i) begin
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            tout_q  <= 1'b0;
        end else begin
            if (cmd_take) begin
                write_q <= bus.cmd_write_i;
                addr_q  <= bus.cmd_addr_i;
                wdata_q <= bus.cmd_write_i ? bus.cmd_wdata_i : '0;
            end
            if (bus_done) begin
                rdata_q <= write_q ? '0 : bus.bus_rdata_i;
                err_q   <= bus.bus_resp_i;
                tout_q  <= 1'b0;
            end else if (tout_hit) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
                tout_q  <= 1'b1;
            end
        end
    end

    assign bus.cmd_ready_o = cmd_ready;
    assign bus.rsp_valid_o = rsp_valid;
    assign bus.rsp_rdata_o = rdata_q;
    assign bus.rsp_err_o   = err_q;
`ifdef UART_BUS_INIT_TIMEOUT_EN
    assign bus.rsp_tout_o  = tout_q;
`else
    assign bus.rsp_tout_o  = 1'b0;
`endif
    assign bus.bus_trans_o = trans;
    assign bus.bus_addr_o  = addr_q;
    assign bus.bus_write_o = write_q;
    assign bus.bus_wdata_o = (state == S_DATA) ? wdata_q : '0;
endmodule
